wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - the in-order pipeline writeback stage (never back-pressured);
  - a multi-cycle execution unit (divider/multiplier class) that returns results out of band.
- Buffers multi-cycle results in a small FIFO and drains them into idle write-port slots.
- Keeps a 32-entry pending-destination scoreboard so decode stalls on reads of registers whose multi-cycle result has not yet been written.
- Sits between the writeback stage, the multi-cycle unit, decode, and the register file write port.

Parameters:
- FIFO_DEPTH, 2, number of buffered multi-cycle results; power of two, at least 2.
- PTR_W, 1, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- p_we  in  1  pipeline writeback write enable.
- p_waddr  in  5  pipeline writeback destination.
- p_wdata  in  32  pipeline writeback data.
- m_valid  in  1  multi-cycle result valid.
- m_ready  out  1  FIFO can accept a result.
- m_waddr  in  5  multi-cycle result destination.
- m_wdata  in  32  multi-cycle result data.
- issue_valid  in  1  decode issuing a multi-cycle op this cycle.
- issue_waddr  in  5  destination of the issued op.
- re1  in  1  decode read port 1 enable.
- raddr1  in  5  decode read port 1 address.
- re2  in  1  decode read port 2 enable.
- raddr2  in  5  decode read port 2 address.
- stallreq  out  1  decode must hold (hazard or issue blocked).
- we  out  1  register file write enable.
- waddr  out  5  register file write address.
- wdata  out  32  register file write data.
- busy  out  1  FIFO non-empty or any pending bit set.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, pending[31:0]=0.
  - Combinational outputs are forced while rst=1: m_ready=0, we=0, waddr=0, wdata=0, stallreq=0, busy=0.
- Pipeline slot is valid when p_we=1 and p_waddr!=0. A write with p_waddr=0 counts as an idle slot.
- Write port mux, combinational, zero added latency:
  - valid pipeline slot: we/waddr/wdata = p_we/p_waddr/p_wdata; the FIFO does not pop.
  - else, FIFO non-empty: we=1, waddr/wdata = FIFO head, and the FIFO pops at the edge.
  - else: we=0, waddr=0, wdata=0.
- FIFO accept:
  - m_ready = !full. A transfer occurs when m_valid && m_ready.
  - A result with m_waddr=0 is accepted and discarded (not pushed).
  - No bypass: an accepted result reaches the write port no earlier than the next cycle.
  - Simultaneous push and pop when full is not allowed. m_ready reflects the registered full flag only.
  - Push and pop in the same cycle when neither empty nor full: count is unchanged.
- Pointer arithmetic: PTR_W-bit pointers wrap modulo FIFO_DEPTH. A separate count of width PTR_W+1 derives full and empty.
- Scoreboard:
  - Set pending[issue_waddr] on issue_valid && !issue_blocked && issue_waddr!=0.
  - Clear pending[waddr] when a FIFO head is written to the register file.
  - Set and clear of the same index in the same cycle: set wins.
  - Pipeline writes never touch pending.
- issue_blocked = issue_valid && pending[issue_waddr] (WAW on an outstanding result). A blocked issue does not set pending; decode re-presents it.
- stallreq = (re1 && raddr1!=0 && pending[raddr1]) || (re2 && raddr2!=0 && pending[raddr2]) || issue_blocked.
- busy = !empty || (pending != 0).
- Starvation: the pipeline always wins. Multi-cycle results wait for idle slots; the FIFO fills, then m_ready=0 back-pressures the unit.
- rst asserted mid-operation: buffered results and pending bits are dropped immediately; nothing is written after reset.

Decomposition:
- Shared defines file: RstEnable/RstDisable, zeroword, NOPRegAddr (5'b0), RegAddrBus/RegBus widths. Use the existing macros; add none new.
- One sub-module: wb_result_fifo (parameterised FIFO_DEPTH, 37-bit entries {waddr,wdata}, push/pop/full/empty/head).
- Arbitration mux and scoreboard stay in the top module.

Test Plan:
- Reset: rst=1 mid-stream with FIFO holding 2 entries and pending[5]=1 -> we=0, m_ready=0, busy=0 immediately. After release, m_ready=1 and pending=0.
- Idle drain:
  - Issue to r5 (pending[5]=1); re1/raddr1=5 -> stallreq=1.
  - m result {5,32'hDEAD_BEEF} accepted at cycle N with p_we=0 -> cycle N+1: we=1, waddr=5, wdata=DEADBEEF.
  - Cycle N+2: pending[5]=0, stallreq=0.
- Pipeline priority: FIFO holds {7,32'h11}; p_we=1, p_waddr=3 for 3 cycles -> port shows r3 writes, FIFO not popped. First cycle with p_we=0 writes r7=0x11.
- Back-pressure: p_we=1 continuously, push 2 results -> m_ready=0 after second. Third result held by unit. One idle slot -> pop, m_ready=1 next cycle.
- Zero address: p_we=1, p_waddr=0 with FIFO non-empty -> FIFO head written that cycle. m result to r0 -> accepted, never written, no pending change.
- WAW and set-wins: pending[9]=1, issue_valid to r9 -> stallreq=1, pending unchanged.
  - Same cycle the r9 result drains while a new issue to r9 is presented (unblocked cycle after) -> pending[9] stays 1.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, null-register constants and the buffered result entry type
package wb_port_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_W = 32;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b0;
    localparam logic [REG_W-1:0] ZERO_WORD = 32'b0;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_W-1:0]      wdata;
    } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: small circular buffer holding multi-cycle results until a write-port slot frees up
import wb_port_arbiter_pkg::*;
module wb_result_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);
    wb_entry_t r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    // count never exceeds FIFO_DEPTH = 2**PTR_W, so its top bit alone means full
    assign full  = r_count[PTR_W];
    assign empty = r_count == '0;
    assign head  = r_mem[r_rd_ptr];
    // storage needs no reset: entries are only read while count says they are valid
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end
    // pointers wrap naturally at FIFO_DEPTH; count tracks occupancy for full/empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline and a buffered multi-cycle unit
import wb_port_arbiter_pkg::*;
module wb_port_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_we,
    input  logic [REG_ADDR_W-1:0] p_waddr,
    input  logic [REG_W-1:0]      p_wdata,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [REG_ADDR_W-1:0] m_waddr,
    input  logic [REG_W-1:0]      m_wdata,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_waddr,
    input  logic                  re1,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic                  re2,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  stallreq,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_W-1:0]      wdata,
    output logic                  busy
);
    logic      w_full;
    logic      w_empty;
    logic      w_p_slot;
    logic      w_push;
    logic      w_pop;
    logic      w_issue_blocked;
    logic      w_issue_set;
    logic      w_hazard;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    wb_entry_t w_din;
    wb_entry_t w_head;
    logic [31:0] r_pending;
    assign w_din    = {m_waddr, m_wdata};
    // writes to r0 are architecturally void, so such a pipeline slot is free for the FIFO
    assign w_p_slot = p_we && p_waddr != NOP_REG_ADDR;
    assign w_pop    = !rst && !w_p_slot && !w_empty;
    // results for r0 complete the handshake but are dropped instead of occupying a slot
    assign w_push   = !rst && m_valid && !w_full && m_waddr != NOP_REG_ADDR;
    assign w_issue_blocked = issue_valid && r_pending[issue_waddr];
    assign w_issue_set = issue_valid && !w_issue_blocked && issue_waddr != NOP_REG_ADDR;
    assign w_hazard = (re1 && raddr1 != NOP_REG_ADDR && r_pending[raddr1])
                   || (re2 && raddr2 != NOP_REG_ADDR && r_pending[raddr2]);
    assign w_set_mask = w_issue_set ? 32'd1 << issue_waddr : 32'd0;
    assign w_clr_mask = w_pop ? 32'd1 << w_head.waddr : 32'd0;
    assign m_ready  = !rst && !w_full;
    assign stallreq = !rst && (w_hazard || w_issue_blocked);
    assign busy     = !rst && (!w_empty || r_pending != 32'd0);
    assign we       = !rst && (w_p_slot || !w_empty);
    assign waddr    = rst ? NOP_REG_ADDR : w_p_slot ? p_waddr : !w_empty ? w_head.waddr : NOP_REG_ADDR;
    assign wdata    = rst ? ZERO_WORD : w_p_slot ? p_wdata : !w_empty ? w_head.wdata : ZERO_WORD;
    wb_result_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .PTR_W(PTR_W)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(w_push),
        .pop(w_pop),
        .din(w_din),
        .head(w_head),
        .full(w_full),
        .empty(w_empty)
    );
    // clear applies before set so a new issue to a just-drained register stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= 32'd0;
        else r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus random traffic checked against a queue-based reference model
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic p_we, m_valid, issue_valid, re1, re2;
    logic [4:0] p_waddr, m_waddr, issue_waddr, raddr1, raddr2;
    logic [31:0] p_wdata, m_wdata;
    logic m_ready, stallreq, we, busy;
    logic [4:0] waddr;
    logic [31:0] wdata;
    int checks = 0;
    int failures = 0;
    wb_entry_t mq[$];
    logic [31:0] mpend = 32'd0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .PTR_W(1)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .stallreq(stallreq), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        p_we = 0; p_waddr = 0; p_wdata = 0;
        m_valid = 0; m_waddr = 0; m_wdata = 0;
        issue_valid = 0; issue_waddr = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    endtask

    function automatic logic rd_hazard(input logic re, input logic [4:0] a);
        return re && a != 0 && mpend[a];
    endfunction

    task automatic cycle();
        logic pslot, blocked, push, e_we;
        logic [4:0] e_addr;
        logic [31:0] e_data;
        @(negedge clk);
        pslot = p_we && p_waddr != 0;
        blocked = issue_valid && mpend[issue_waddr];
        e_we = 0; e_addr = 0; e_data = 0;
        if (pslot) begin
            e_we = 1; e_addr = p_waddr; e_data = p_wdata;
        end else if (mq.size() != 0) begin
            e_we = 1; e_addr = mq[0].waddr; e_data = mq[0].wdata;
        end
        chk("we", we, e_we);
        chk("waddr", waddr, e_addr);
        chk("wdata", wdata, e_data);
        chk("m_ready", m_ready, mq.size() < DEPTH);
        chk("stallreq", stallreq, rd_hazard(re1, raddr1) || rd_hazard(re2, raddr2) || blocked);
        chk("busy", busy, mq.size() != 0 || mpend != 0);
        @(posedge clk);
        push = m_valid && mq.size() < DEPTH && m_waddr != 0;
        if (!pslot && mq.size() != 0) begin
            mpend[mq[0].waddr] = 1'b0;
            void'(mq.pop_front());
        end
        if (push) mq.push_back({m_waddr, m_wdata});
        if (issue_valid && !blocked && issue_waddr != 0) mpend[issue_waddr] = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1; #1;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stallreq, 0);
        mq.delete();
        mpend = 32'd0;
        @(posedge clk); #1;
        rst = 0; #1;
        chk("rel_m_ready", m_ready, 1);
        chk("rel_busy", busy, 0);
    endtask

    initial begin
        idle();
        do_reset();
        // idle drain of an issued r5 result
        issue_valid = 1; issue_waddr = 5;
        cycle();
        idle(); re1 = 1; raddr1 = 5; #1;
        chk("r5_stall", stallreq, 1);
        m_valid = 1; m_waddr = 5; m_wdata = 32'hDEAD_BEEF;
        cycle();
        m_valid = 0; #1;
        chk("drain_we", we, 1);
        chk("drain_waddr", waddr, 5);
        chk("drain_wdata", wdata, 32'hDEAD_BEEF);
        chk("drain_stall", stallreq, 1);
        cycle();
        chk("r5_cleared", stallreq, 0);
        cycle();
        // pipeline priority over a buffered r7 result
        idle(); m_valid = 1; m_waddr = 7; m_wdata = 32'h11; p_we = 1; p_waddr = 3; p_wdata = 32'h33;
        cycle();
        m_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("prio_waddr", waddr, 3);
            chk("prio_busy", busy, 1);
            cycle();
        end
        p_we = 0; #1;
        chk("prio_r7_addr", waddr, 7);
        chk("prio_r7_data", wdata, 32'h11);
        cycle();
        // back-pressure under continuous pipeline writes
        idle(); p_we = 1; p_waddr = 4; m_valid = 1;
        m_waddr = 10; m_wdata = 32'hA; cycle();
        m_waddr = 11; m_wdata = 32'hB; cycle();
        #1 chk("bp_full", m_ready, 0);
        m_waddr = 12; m_wdata = 32'hC; cycle(); cycle();
        p_we = 0; cycle();
        p_we = 1; #1 chk("bp_free", m_ready, 1);
        cycle();
        m_valid = 0;
        // zero-address pipeline slot drains the FIFO; r0 result is dropped
        p_waddr = 0; #1 chk("zero_slot_we", we, 1);
        chk("zero_slot_addr", waddr, 11);
        for (int i = 0; i < 4; i++) cycle();
        idle(); m_valid = 1; m_waddr = 0; m_wdata = 32'h77; cycle();
        m_valid = 0; #1 chk("r0_dropped_we", we, 0);
        chk("r0_busy", busy, 0);
        cycle();
        // WAW block on r9, then re-issue once drained
        issue_valid = 1; issue_waddr = 9; cycle();
        #1 chk("waw_stall", stallreq, 1);
        m_valid = 1; m_waddr = 9; m_wdata = 32'h99; cycle();
        m_valid = 0; cycle();
        cycle();
        #1 chk("waw_reissue", stallreq, 1);
        issue_valid = 0; re1 = 1; raddr1 = 9; cycle();
        // set wins over a same-cycle clear of an unissued r20 result
        idle(); m_valid = 1; m_waddr = 20; m_wdata = 32'h20; cycle();
        m_valid = 0; issue_valid = 1; issue_waddr = 20; cycle();
        idle(); re2 = 1; raddr2 = 20; #1 chk("set_wins", stallreq, 1);
        cycle();
        // reset mid-stream with two buffered results and r5 pending
        idle(); issue_valid = 1; issue_waddr = 5; p_we = 1; p_waddr = 2; cycle();
        issue_valid = 0; m_valid = 1; m_waddr = 6; cycle();
        m_waddr = 8; cycle();
        m_valid = 0; #1 chk("pre_rst_full", m_ready, 0);
        do_reset();
        idle(); re1 = 1; raddr1 = 5; cycle();
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            p_we = $urandom_range(0, 9) < 6;
            p_waddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            p_wdata = $urandom;
            m_valid = $urandom_range(0, 1);
            m_waddr = 5'($urandom_range(0, 15));
            m_wdata = $urandom;
            issue_valid = $urandom_range(0, 9) < 3;
            issue_waddr = 5'($urandom_range(0, 15));
            re1 = $urandom_range(0, 1);
            raddr1 = 5'($urandom_range(0, 15));
            re2 = $urandom_range(0, 1);
            raddr2 = 5'($urandom_range(0, 15));
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
